// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the boot-time system-ID check master.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_RSP_ID,
    ST_REQ_TS,
    ST_RSP_TS,
    ST_CHECK,
    ST_FIN
  } state_e;

  localparam logic SYSID_ID_ADDR = 1'b0;
  localparam logic SYSID_TS_ADDR = 1'b1;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sysid_check_timeout.sv
// Per-attempt watchdog: loadable down-counter whose expired flag rises on the last allowed cycle.
module sysid_check_timeout #(
  parameter int unsigned  W    = 8,
  parameter logic [W-1:0] LOAD = '1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (load) begin
      count   <= LOAD;
      expired <= (LOAD == '0);
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (en && count != '0) begin
      count   <= count - W'(1);
      expired <= (count == W'(1));
    end
  end

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words at boot
// and reports pass, mismatch or timeout status.
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1427262868,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned RETRIES            = 2,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_seen,
  output logic [31:0] ts_seen
);

  localparam int unsigned      TMO_W    = cnt_width(TIMEOUT_CYCLES - 1);
  localparam int unsigned      RTY_W    = cnt_width(RETRIES);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LOAD = RTY_W'(RETRIES);

  state_e           state;
  logic             auto_pend;
  logic [RTY_W-1:0] retries_left;
  logic             tmo_expired;

  // Attempt bookkeeping shared by the FSM and the watchdog.
  logic in_req, in_rsp, accept, got, abandon, retry, kick, tmo_load, tmo_en;
  assign in_req   = (state == ST_REQ_ID) || (state == ST_REQ_TS);
  assign in_rsp   = (state == ST_RSP_ID) || (state == ST_RSP_TS);
  assign accept   = in_req && !avm_waitrequest;
  assign got      = in_rsp && avm_readdatavalid;
  assign abandon  = tmo_expired && ((in_req && !accept) || (in_rsp && !got));
  assign retry    = abandon && (retries_left != '0);
  assign kick     = (state == ST_IDLE) && (start || auto_pend);
  assign tmo_load = kick || retry || ((state == ST_RSP_ID) && got);
  assign tmo_en   = in_req || in_rsp;

  sysid_check_timeout #(
    .W    (TMO_W),
    .LOAD (TMO_LOAD)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tmo_load),
    .clear   (!tmo_en),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      auto_pend    <= AUTO_START;
      retries_left <= '0;
      avm_address  <= SYSID_ID_ADDR;
      avm_read     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      id_mismatch  <= 1'b0;
      ts_mismatch  <= 1'b0;
      timeout      <= 1'b0;
      id_seen      <= '0;
      ts_seen      <= '0;
    end else begin
      auto_pend <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (kick) begin
            state        <= ST_REQ_ID;
            avm_address  <= SYSID_ID_ADDR;
            avm_read     <= 1'b1;
            busy         <= 1'b1;
            pass         <= 1'b0;
            id_mismatch  <= 1'b0;
            ts_mismatch  <= 1'b0;
            timeout      <= 1'b0;
            retries_left <= RTY_LOAD;
          end
        end
        ST_REQ_ID, ST_REQ_TS: begin
          // An accepted read always proceeds; the read stays asserted across a retry.
          if (accept) begin
            state    <= (state == ST_REQ_ID) ? ST_RSP_ID : ST_RSP_TS;
            avm_read <= 1'b0;
          end else if (retry) begin
            retries_left <= retries_left - RTY_W'(1);
          end else if (abandon) begin
            state    <= ST_FIN;
            avm_read <= 1'b0;
            timeout  <= 1'b1;
            done     <= 1'b1;
          end
        end
        ST_RSP_ID, ST_RSP_TS: begin
          if (got) begin
            if (state == ST_RSP_ID) begin
              id_seen     <= avm_readdata;
              state       <= ST_REQ_TS;
              avm_address <= SYSID_TS_ADDR;
              avm_read    <= 1'b1;
            end else begin
              ts_seen <= avm_readdata;
              state   <= ST_CHECK;
            end
          end else if (retry) begin
            retries_left <= retries_left - RTY_W'(1);
            state        <= (state == ST_RSP_ID) ? ST_REQ_ID : ST_REQ_TS;
            avm_read     <= 1'b1;
          end else if (abandon) begin
            state   <= ST_FIN;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        ST_CHECK: begin
          id_mismatch <= (id_seen != EXPECTED_ID);
          ts_mismatch <= (ts_seen != EXPECTED_TIMESTAMP);
          pass        <= (id_seen == EXPECTED_ID) && (ts_seen == EXPECTED_TIMESTAMP);
          state       <= ST_FIN;
          done        <= 1'b1;
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          avm_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomized bench for sysid_check_master: a configurable Avalon slave plus a
// cycle-level outcome model of each check.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1427262868;
  localparam int unsigned TMO    = 8;
  localparam int unsigned RTY    = 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_address, avm_read, busy, done, pass;
  logic        id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_seen, ts_seen;

  always #5 clock = ~clock;

  sysid_check_master #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TMO),
    .RETRIES            (RTY),
    .AUTO_START         (1'b1)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_mismatch       (id_mismatch),
    .ts_mismatch       (ts_mismatch),
    .timeout           (timeout),
    .id_seen           (id_seen),
    .ts_seen           (ts_seen)
  );

  // Slave behaviour per word address, set by the main sequence.
  int unsigned cfg_wait[2];
  int unsigned cfg_delay[2];
  bit          cfg_never[2];
  logic [31:0] cfg_data[2];

  int unsigned acc_cnt[2];
  int unsigned req_cycles[2];
  int unsigned spur_req = 0, spur_done = 0;
  int unsigned cyc = 0, done_cnt = 0, done_cyc = 0;
  int unsigned n_checks = 0, n_pass = 0;
  logic [31:0] exp_id_seen = '0, exp_ts_seen = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_cfg_default();
    for (int a = 0; a < 2; a++) begin
      cfg_wait[a]  = 0;
      cfg_delay[a] = 1;
      cfg_never[a] = 1'b0;
    end
    cfg_data[0] = EXP_ID;
    cfg_data[1] = EXP_TS;
  endtask

  // Slave and monitor: sample at the falling edge, drive inputs for the coming rising edge.
  initial begin
    int unsigned wait_left;
    bit          in_req;
    int unsigned due_q[$];
    logic [31:0] dat_q[$];
    int unsigned a;
    in_req = 1'b0;
    wait_left = 0;
    for (int i = 0; i < 2; i++) begin
      acc_cnt[i] = 0;
      req_cycles[i] = 0;
    end
    forever begin
      @(negedge clock);
      cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!reset_n) begin
        in_req = 1'b0;
        due_q.delete();
        dat_q.delete();
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
      end else begin
        if (avm_read) begin
          a = 32'(avm_address);
          req_cycles[a]++;
          if (!in_req) begin
            in_req = 1'b1;
            wait_left = cfg_wait[a];
          end
          if (wait_left > 0) begin
            avm_waitrequest = 1'b1;
            wait_left--;
          end else begin
            avm_waitrequest = 1'b0;
            acc_cnt[a]++;
            in_req = 1'b0;
            if (!cfg_never[a]) begin
              due_q.push_back(cyc + cfg_delay[a]);
              dat_q.push_back(cfg_data[a]);
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
          in_req = 1'b0;
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          void'(due_q.pop_front());
          avm_readdata      = dat_q.pop_front();
          avm_readdatavalid = 1'b1;
        end else if (spur_req != spur_done) begin
          spur_done++;
          avm_readdata      = 32'hDEAD_BEEF;
          avm_readdatavalid = 1'b1;
        end else begin
          avm_readdata      = $urandom();
          avm_readdatavalid = 1'b0;
        end
      end
    end
  end

  // Expected outcome of one check from the slave configuration: each attempt either
  // completes in wait+delay+1 cycles or burns the full timeout budget.
  task automatic model(output int unsigned lat, output bit e_pass, output bit e_idm,
                       output bit e_tsm, output bit e_to,
                       output int unsigned e_acc0, output int unsigned e_acc1,
                       output int unsigned e_req0, output int unsigned e_req1);
    int unsigned left;
    int unsigned acc[2];
    int unsigned req[2];
    logic [31:0] seen[2];
    bit ok, fin;
    left = RTY;
    acc[0] = 0; acc[1] = 0;
    req[0] = 0; req[1] = 0;
    seen[0] = exp_id_seen;
    seen[1] = exp_ts_seen;
    lat = 1;
    e_to = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (!e_to) begin
        ok  = !cfg_never[w] && (cfg_wait[w] + cfg_delay[w] <= TMO - 1);
        fin = 1'b0;
        while (!fin) begin
          req[w] += cfg_wait[w] + 1;
          acc[w] += 1;
          if (ok) begin
            lat += cfg_wait[w] + cfg_delay[w] + 1;
            seen[w] = cfg_data[w];
            fin = 1'b1;
          end else begin
            lat += TMO;
            if (left > 0) left--;
            else begin
              e_to = 1'b1;
              fin = 1'b1;
            end
          end
        end
      end
    end
    e_idm = 1'b0; e_tsm = 1'b0; e_pass = 1'b0;
    if (!e_to) begin
      lat += 1;
      e_idm  = (seen[0] != EXP_ID);
      e_tsm  = (seen[1] != EXP_TS);
      e_pass = !e_idm && !e_tsm;
    end
    exp_id_seen = seen[0];
    exp_ts_seen = seen[1];
    e_acc0 = acc[0]; e_acc1 = acc[1];
    e_req0 = req[0]; e_req1 = req[1];
  endtask

  // Trigger a check (start pulse or reset release), wait for done, compare everything.
  task automatic run_check(input bit by_reset, input int unsigned extra_start, input bit start_at_done);
    int unsigned lat, a0, a1, r0, r1, s, b_done, guard;
    int unsigned b_acc[2];
    int unsigned b_req[2];
    bit e_pass, e_idm, e_tsm, e_to;
    model(lat, e_pass, e_idm, e_tsm, e_to, a0, a1, r0, r1);
    @(negedge clock); #1;
    for (int i = 0; i < 2; i++) begin
      b_acc[i] = acc_cnt[i];
      b_req[i] = req_cycles[i];
    end
    b_done = done_cnt;
    s = cyc;
    if (by_reset) reset_n = 1'b1;
    else start = 1'b1;
    guard = 0;
    while (done_cnt == b_done && guard < 200) begin
      @(negedge clock); #1;
      start = (extra_start > 0) && (cyc - s == extra_start);
      guard++;
    end
    start = 1'b0;
    check_eq("done_seen", 32'(guard < 200), 1);
    check_eq("latency", done_cyc - s, lat);
    check_eq("pass", pass, e_pass);
    check_eq("id_mismatch", id_mismatch, e_idm);
    check_eq("ts_mismatch", ts_mismatch, e_tsm);
    check_eq("timeout", timeout, e_to);
    check_eq("id_seen", id_seen, exp_id_seen);
    check_eq("ts_seen", ts_seen, exp_ts_seen);
    check_eq("id_accepts", acc_cnt[0] - b_acc[0], a0);
    check_eq("ts_accepts", acc_cnt[1] - b_acc[1], a1);
    check_eq("id_req_cycles", req_cycles[0] - b_req[0], r0);
    check_eq("ts_req_cycles", req_cycles[1] - b_req[1], r1);
    if (start_at_done) start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_eq("single_done", done_cnt - b_done, 1);
    check_eq("idle_after", busy, 0);
    check_eq("flags_hold", {pass, id_mismatch, ts_mismatch, timeout}, {e_pass, e_idm, e_tsm, e_to});
  endtask

  initial begin
    int unsigned b_acc1, b_done, guard;
    set_cfg_default();

    // Outputs quiet while reset is held.
    repeat (3) @(negedge clock);
    #1;
    check_eq("rst_ctrl", {avm_read, avm_address, busy, done}, 0);
    check_eq("rst_flags", {pass, id_mismatch, ts_mismatch, timeout}, 0);
    check_eq("rst_seen", id_seen | ts_seen, 0);

    // Auto-start baseline after reset release.
    run_check(1'b1, 0, 1'b0);

    // ID word differs.
    set_cfg_default();
    cfg_data[0] = 32'h0000_0007;
    run_check(1'b0, 0, 1'b0);

    // Timestamp read stalled three cycles; a start coincident with done is dropped.
    set_cfg_default();
    cfg_wait[1] = 3;
    run_check(1'b0, 0, 1'b1);

    // Reset while waiting for the timestamp response.
    set_cfg_default();
    cfg_data[0] = 32'h0000_1234;
    cfg_delay[1] = 3;
    @(negedge clock); #1;
    b_acc1 = acc_cnt[1];
    b_done = done_cnt;
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    guard = 0;
    while (acc_cnt[1] == b_acc1 && guard < 100) begin
      @(negedge clock); #1;
      guard++;
    end
    check_eq("rst_reach_ts", 32'(guard < 100), 1);
    check_eq("mid_id_seen", id_seen, 32'h0000_1234);
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    check_eq("abort_read", avm_read, 0);
    check_eq("abort_flags", {busy, done, pass, id_mismatch, ts_mismatch, timeout}, 0);
    check_eq("abort_id_seen", id_seen, 0);
    repeat (4) @(negedge clock);
    #1;
    check_eq("abort_no_done", done_cnt - b_done, 0);
    exp_id_seen = '0;
    exp_ts_seen = '0;
    set_cfg_default();
    run_check(1'b1, 0, 1'b0);

    // ID response never arrives: two ID attempts, then timeout without a TS read.
    set_cfg_default();
    cfg_never[0] = 1'b1;
    run_check(1'b0, 0, 1'b0);

    // Spurious readdatavalid while idle, then a start pulse while busy.
    set_cfg_default();
    spur_req++;
    repeat (4) @(negedge clock);
    #1;
    check_eq("spur_id_seen", id_seen, exp_id_seen);
    check_eq("spur_ts_seen", ts_seen, exp_ts_seen);
    run_check(1'b0, 2, 1'b0);

    // Randomized checks.
    for (int n = 0; n < 25; n++) begin
      for (int a = 0; a < 2; a++) begin
        cfg_wait[a]  = $urandom_range(0, 3);
        cfg_delay[a] = $urandom_range(1, 3);
        cfg_never[a] = ($urandom_range(0, 7) == 0);
      end
      cfg_data[0] = ($urandom_range(0, 1) == 0) ? EXP_ID : 32'($urandom());
      cfg_data[1] = ($urandom_range(0, 1) == 0) ? EXP_TS : EXP_TS ^ (32'h1 << $urandom_range(0, 31));
      run_check(1'b0, ($urandom_range(0, 3) == 0) ? 3 : 0, 1'(($urandom_range(0, 3) == 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
